// File: rtl/seven_segment_pkg.sv
// Shared types and segment encodings for the multiplexed seven-segment display.
// Segment bytes are active-low: bits 7..1 = a..g, bit 0 = decimal point.
package seven_segment_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hFD;

    // Glyph table 0..F with the decimal point off.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h03;
            4'h1:    seg = 8'h9F;
            4'h2:    seg = 8'h25;
            4'h3:    seg = 8'h0D;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h49;
            4'h6:    seg = 8'h41;
            4'h7:    seg = 8'h1F;
            4'h8:    seg = 8'h01;
            4'h9:    seg = 8'h09;
            4'hA:    seg = 8'h11;
            4'hB:    seg = 8'hC1;
            4'hC:    seg = 8'h63;
            4'hD:    seg = 8'h85;
            4'hE:    seg = 8'h61;
            4'hF:    seg = 8'h71;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_mux_if.sv
// Value hand-off channel into the display: a valid/ready transfer of a value,
// its radix and its decimal points.
interface seven_segment_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_BITS  = 14
);
    logic [DATA_BITS-1:0]  data_in;
    logic                  data_valid;
    logic                  data_ready;
    logic                  hex_mode;
    logic [NUM_DIGITS-1:0] dp_in;

    modport master (output data_in, output data_valid, output hex_mode, output dp_in,
                    input  data_ready);
    modport slave  (input  data_in, input  data_valid, input  hex_mode, input  dp_in,
                    output data_ready);
endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-digits converter: one double-dabble step per cycle in
// decimal mode, a single-cycle nibble load in hex mode. done/digits are valid together.
module bcd_converter_seq
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_BITS  = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    hex_mode,
    input  logic [DATA_BITS-1:0]    data_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    overflow
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [63:0] DEC_LIMIT = 64'(10 ** NUM_DIGITS);

    state_t               state_r;
    logic                 hex_r;
    logic                 ovf_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [BCD_W-1:0]     bcd_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [63:0]          wide_s;
    logic [BCD_W-1:0]     step_s;
    logic                 last_s;

    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = (adj[4*i +: 4] >= 4'd5) ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    assign wide_s   = 64'(data_in);
    assign step_s   = dd_step(bcd_r, shift_r[DATA_BITS-1]);
    assign last_s   = (state_r == ST_CONVERT) && (hex_r || (cnt_r == CNT_W'(DATA_BITS - 1)));
    assign busy     = (state_r == ST_CONVERT);
    assign done     = last_s;
    // The final double-dabble step is presented combinationally so the caller can latch it on the last cycle.
    assign digits   = hex_r ? bcd_r : step_s;
    assign overflow = ovf_r;

    // Conversion FSM and datapath; overflow is judged once from the raw input at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            hex_r   <= 1'b0;
            ovf_r   <= 1'b0;
            shift_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_CONVERT;
                        hex_r   <= hex_mode;
                        shift_r <= data_in;
                        cnt_r   <= '0;
                        if (hex_mode) begin
                            bcd_r <= wide_s[BCD_W-1:0];
                            ovf_r <= (wide_s >> BCD_W) != 64'd0;
                        end else begin
                            bcd_r <= '0;
                            ovf_r <= wide_s >= DEC_LIMIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    shift_r <= shift_r << 1;
                    bcd_r   <= step_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    state_r <= last_s ? ST_IDLE : ST_CONVERT;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver: accepts a value over a valid/ready channel,
// converts it, and scans the digits with PWM brightness and leading-zero blanking.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_BITS    = 14,
    parameter int DIGIT_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_segment_mux_if.slave    bus,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [NUM_DIGITS-1:0] enable,
    output logic [7:0]            led_out
);
    localparam int PHASE_LEN = DIGIT_CYCLES / 16;
    localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W     = 4 * NUM_DIGITS;

    logic                  start_s;
    logic                  conv_busy_s;
    logic                  conv_done_s;
    logic [BCD_W-1:0]      conv_digits_s;
    logic                  conv_ovf_s;
    logic [BCD_W-1:0]      digits_r;
    logic [NUM_DIGITS-1:0] dp_r;
    logic [NUM_DIGITS-1:0] dp_pend_r;
    logic                  ovf_r;
    logic [SUB_W-1:0]      sub_r;
    logic [3:0]            phase_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NUM_DIGITS-1:0] enable_r;
    logic [7:0]            led_r;
    logic                  run_v;
    logic [NUM_DIGITS-1:0] zero_above_s;
    logic [3:0]            nib_s;
    logic                  dp_sel_s;
    logic                  blank_s;
    logic                  lit_s;
    logic [7:0]            seg_s;

    assign start_s        = bus.data_valid && !conv_busy_s;
    assign bus.data_ready = !conv_busy_s;
    assign enable         = enable_r;
    assign led_out        = led_r;

    bcd_converter_seq #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_BITS  (DATA_BITS)
    ) u_conv (
        .clk      (clk),
        .reset    (reset),
        .start    (start_s),
        .hex_mode (bus.hex_mode),
        .data_in  (bus.data_in),
        .busy     (conv_busy_s),
        .done     (conv_done_s),
        .digits   (conv_digits_s),
        .overflow (conv_ovf_s)
    );

    // Display registers change only on the converter's final cycle, so partial results are never shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_r  <= '0;
            dp_r      <= '0;
            dp_pend_r <= '0;
            ovf_r     <= 1'b0;
        end else begin
            dp_pend_r <= start_s ? bus.dp_in : dp_pend_r;
            if (conv_done_s) begin
                digits_r <= conv_digits_s;
                dp_r     <= dp_pend_r;
                ovf_r    <= conv_ovf_s;
            end else begin
                digits_r <= digits_r;
                dp_r     <= dp_r;
                ovf_r    <= ovf_r;
            end
        end
    end

    // Scan position: sub-phase tick, 16 PWM phases per slot, digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_r   <= '0;
            phase_r <= 4'd0;
            idx_r   <= '0;
        end else if (sub_r == SUB_W'(PHASE_LEN - 1)) begin
            sub_r   <= '0;
            phase_r <= phase_r + 4'd1;
            if (phase_r == 4'd15) begin
                idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            sub_r <= sub_r + SUB_W'(1);
        end
    end

    // Segment pattern and blanking decision for the currently scanned digit.
    always_comb begin
        run_v        = 1'b1;
        zero_above_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_v           = run_v & (digits_r[4*i +: 4] == 4'd0);
            zero_above_s[i] = run_v;
        end
        nib_s    = digits_r[4*idx_r +: 4];
        dp_sel_s = dp_r[idx_r];
        blank_s  = blank_lz && (idx_r != '0) && !ovf_r && zero_above_s[idx_r] && !dp_sel_s;
        lit_s    = (phase_r <= brightness);
        seg_s    = ovf_r ? SEG_DASH : glyph(nib_s);
        seg_s[0] = seg_s[0] & ~dp_sel_s;
    end

    // Registered drive of digit enables and segments.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r <= '1;
            led_r    <= SEG_BLANK;
        end else if (blank_s) begin
            enable_r <= '1;
            led_r    <= SEG_BLANK;
        end else begin
            enable_r <= lit_s ? ~(NUM_DIGITS'(1) << idx_r) : '1;
            led_r    <= seg_s;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: a value-level model of what every digit slot must
// show is compared every cycle, plus literal glyph/latency/duty expectations.
module tb_seven_segment_mux;
    localparam int ND = 4;
    localparam int DB = 14;
    localparam int DC = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          blank_lz;
    logic [3:0]    brightness;
    logic [ND-1:0] enable;
    logic [7:0]    led_out;

    seven_segment_mux_if #(.NUM_DIGITS(ND), .DATA_BITS(DB)) bus ();

    seven_segment_mux #(.NUM_DIGITS(ND), .DATA_BITS(DB), .DIGIT_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .enable     (enable),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] glyph_tbl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                   8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: displayed value as an integer, scan position from elapsed cycles.
    int          m_tick, m_disp, m_rem, m_pend, m_slot, m_phase, m_base, m_pw, m_digit;
    bit          m_disp_hex, m_pend_hex, m_busy, m_ovf, m_blank, m_dpb, model_ok = 1'b0;
    logic [3:0]  m_disp_dp, m_pend_dp, exp_en;
    logic [7:0]  exp_led;
    bit          exp_ready;
    bit          cmp_on = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            m_tick = 0; m_disp = 0; m_disp_hex = 0; m_disp_dp = 4'd0;
            m_busy = 0; m_rem = 0;
            exp_en = 4'hF; exp_led = 8'hFF; exp_ready = 1'b1; model_ok = 1'b1;
        end else begin
            m_slot  = (m_tick / DC) % ND;
            m_phase = (m_tick % DC) / (DC / 16);
            m_base  = m_disp_hex ? 16 : 10;
            m_pw    = m_base ** m_slot;
            m_ovf   = m_disp >= m_base ** ND;
            m_digit = (m_disp / m_pw) % m_base;
            m_dpb   = m_disp_dp[m_slot];
            m_blank = blank_lz && (m_slot > 0) && !m_ovf && (m_disp < m_pw) && !m_dpb;
            if (m_blank) begin
                exp_en  = 4'hF;
                exp_led = 8'hFF;
            end else begin
                exp_en  = (m_phase <= int'(brightness)) ? ~(4'b0001 << m_slot) : 4'hF;
                exp_led = m_ovf ? 8'hFD : glyph_tbl[m_digit];
                if (m_dpb) exp_led[0] = 1'b0;
            end
            m_tick++;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_disp = m_pend; m_disp_hex = m_pend_hex; m_disp_dp = m_pend_dp; m_busy = 0;
                end
            end else if (bus.data_valid) begin
                m_pend = int'(bus.data_in); m_pend_hex = bus.hex_mode; m_pend_dp = bus.dp_in;
                m_busy = 1; m_rem = bus.hex_mode ? 1 : DB;
            end
            exp_ready = !m_busy;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok && cmp_on) begin
            check("enable", enable, exp_en);
            check("led_out", led_out, exp_led);
            check("data_ready", bus.data_ready, exp_ready);
            check("one_enable_low", ($countones(~enable) <= 1), 1);
        end
    end

    task automatic send(input int val, input bit hx, input logic [3:0] dp);
        int n = 0;
        int lows = 0;
        @(negedge clk);
        bus.data_valid = 1'b1; bus.data_in = DB'(val); bus.hex_mode = hx; bus.dp_in = dp;
        while (bus.data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", (n < 100), 1);
        @(negedge clk);
        bus.data_valid = 1'b0;
        while (bus.data_ready === 1'b0 && lows < 50) begin
            lows++;
            @(negedge clk);
        end
        check(hx ? "latency_hex" : "latency_dec", lows, hx ? 1 : DB);
    endtask

    task automatic expect_slot(input string name, input logic [3:0] en_lit, input logic [7:0] led_lit);
        int n = 0;
        @(negedge clk);
        while (enable !== en_lit && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_en"}, enable, en_lit);
        check({name, "_led"}, led_out, led_lit);
    endtask

    int lowcnt [ND];

    task automatic count_frame();
        for (int b = 0; b < ND; b++) lowcnt[b] = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < ND * DC; c++) begin
            @(negedge clk);
            for (int b = 0; b < ND; b++) if (enable[b] === 1'b0) lowcnt[b]++;
        end
    endtask

    initial begin
        reset = 1'b1; bus.data_valid = 1'b0; bus.data_in = '0; bus.hex_mode = 1'b0; bus.dp_in = 4'd0;
        blank_lz = 1'b0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_enable", enable, 4'hF);
        check("rst_led", led_out, 8'hFF);
        check("rst_ready", bus.data_ready, 1);
        reset = 1'b0;
        expect_slot("zero_d0", 4'b1110, 8'h03);

        send(1234, 1'b0, 4'd0);
        expect_slot("d1234_0", 4'b1110, 8'h99);
        expect_slot("d1234_1", 4'b1101, 8'h0D);
        expect_slot("d1234_2", 4'b1011, 8'h25);
        expect_slot("d1234_3", 4'b0111, 8'h9F);
        count_frame();
        for (int b = 0; b < ND; b++) check("duty15", lowcnt[b], 32);
        brightness = 4'd3;
        count_frame();
        for (int b = 0; b < ND; b++) check("duty3", lowcnt[b], 8);
        brightness = 4'd0;
        count_frame();
        for (int b = 0; b < ND; b++) check("duty0", lowcnt[b], 2);
        brightness = 4'd15;

        blank_lz = 1'b1;
        send(42, 1'b0, 4'd0);
        count_frame();
        check("blank_d3", lowcnt[3], 0);
        check("blank_d2", lowcnt[2], 0);
        check("blank_d1", lowcnt[1], 32);
        check("blank_d0", lowcnt[0], 32);
        expect_slot("d42_1", 4'b1101, 8'h99);
        expect_slot("d42_0", 4'b1110, 8'h25);
        blank_lz = 1'b0;
        expect_slot("d42_3", 4'b0111, 8'h03);
        expect_slot("d42_2", 4'b1011, 8'h03);
        blank_lz = 1'b1;
        send(42, 1'b0, 4'b0100);
        expect_slot("d42dp_2", 4'b1011, 8'h02);
        count_frame();
        check("blank_dp_d3", lowcnt[3], 0);

        send(10000, 1'b0, 4'd0);
        expect_slot("ovf_0", 4'b1110, 8'hFD);
        expect_slot("ovf_1", 4'b1101, 8'hFD);
        expect_slot("ovf_2", 4'b1011, 8'hFD);
        expect_slot("ovf_3", 4'b0111, 8'hFD);
        blank_lz = 1'b0;

        send(14'h2BCD, 1'b1, 4'd0);
        expect_slot("hex_0", 4'b1110, 8'h85);
        expect_slot("hex_1", 4'b1101, 8'h63);
        expect_slot("hex_2", 4'b1011, 8'hC1);
        expect_slot("hex_3", 4'b0111, 8'h25);

        // Streaming offers: only offers seen with data_ready high are taken.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.data_valid = 1'b1;
            bus.data_in    = DB'($urandom_range(0, 16383));
            bus.hex_mode   = 1'($urandom_range(0, 1));
            bus.dp_in      = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        bus.data_valid = 1'b0;

        for (int k = 0; k < 30; k++) begin
            blank_lz   = 1'($urandom_range(0, 1));
            brightness = 4'($urandom_range(0, 15));
            send(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 200)) @(negedge clk);
        end

        // Reset in the middle of a decimal conversion.
        blank_lz = 1'b0; brightness = 4'd15;
        @(negedge clk);
        bus.data_valid = 1'b1; bus.data_in = DB'(9876); bus.hex_mode = 1'b0; bus.dp_in = 4'b1111;
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_enable", enable, 4'hF);
        check("midrst_led", led_out, 8'hFF);
        reset = 1'b0;
        expect_slot("midrst_d0", 4'b1110, 8'h03);
        expect_slot("midrst_d3", 4'b0111, 8'h03);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DATA_BITS, default 14, width of the unsigned binary input.
REQ-003 SHALL have parameter DIGIT_CYCLES, default 250000, clock cycles per digit slot (multiple of 16, >= 16).
REQ-004 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port data_in, input, DATA_BITS, unsigned value to display.
REQ-007 SHALL have port data_valid, input, 1, data_in/hex_mode/dp_in offered.
REQ-008 SHALL have port data_ready, output, 1, block can accept a new value.
REQ-009 SHALL have port hex_mode, input, 1, 1 = hexadecimal display, 0 = decimal.
REQ-010 SHALL have port dp_in, input, NUM_DIGITS, decimal point per digit (bit i = digit i), active-high.
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable (sampled live).
REQ-012 SHALL have port brightness, input, 4, duty level 0..15 (sampled live).
REQ-013 SHALL have port enable, output, NUM_DIGITS, active-low digit select; bit 0 = least significant digit.
REQ-014 SHALL have port led_out, output, 8, active-low segments; bits 7..1 = a..g, bit 0 = dp.

Function
REQ-015 SHALL transfer data_in, hex_mode, dp_in on a cycle with data_valid and data_ready both high (handshake cycle T).
REQ-016 SHALL implement FSM IDLE -> CONVERT -> IDLE; data_ready high only in IDLE.
REQ-017 Decimal mode: CONVERT SHALL perform one shift-add-3 double-dabble step per cycle for DATA_BITS cycles (T+1..T+DATA_BITS).
REQ-018 Hex mode: CONVERT SHALL last one cycle, loading data_in nibbles directly.
REQ-019 SHALL update the digit register and dp register atomically on the last CONVERT cycle; new digits visible from cycle T+DATA_BITS+1 (decimal) or T+2 (hex); data_ready high again that same cycle.
REQ-020 During CONVERT the previously displayed value SHALL remain on display unchanged.
REQ-021 Overflow (decimal value >= 10^NUM_DIGITS, or hex value >= 16^NUM_DIGITS) SHALL display a dash (led_out 8'hFD, dp per dp_in) on every digit.
REQ-022 Glyphs SHALL be 0..9 = 03,9F,25,0D,99,49,41,1F,01,09; A..F = 11,C1,63,85,61,71 (hex, dp bit off); dp set clears bit 0.
REQ-023 Digit index SHALL advance every DIGIT_CYCLES cycles, 0..NUM_DIGITS-1, wrapping to 0.
REQ-024 Each slot SHALL be split into 16 phases of DIGIT_CYCLES/16; selected enable bit low only in phases 0..brightness; all enable bits high otherwise.
REQ-025 With blank_lz=1, digit i>0 SHALL be blanked (enable bit high, led_out 8'hFF) when digit i and all higher digits are zero and its dp bit is 0; digit 0 never blanked; no blanking on overflow.
REQ-026 enable and led_out SHALL be registered; at most one enable bit low at any time.
REQ-027 A data_valid while data_ready is low SHALL be ignored (no queueing).

Reset
REQ-028 On reset: FSM IDLE, data_ready 1 next cycle, digit register 0, dp register 0, scan/phase counters 0, enable all ones, led_out 8'hFF.
REQ-029 Reset mid-CONVERT SHALL abort conversion; display register returns to 0, not the partial result.

Structure
REQ-030 Package seven_segment_pkg SHALL hold the FSM state enum, glyph table 0..F, SEG_BLANK (8'hFF) and SEG_DASH (8'hFD).
REQ-031 Sequential converter SHALL be sub-module bcd_converter_seq (start/busy/done, NUM_DIGITS*4-bit output, overflow flag).

Verification (NUM_DIGITS=4, DATA_BITS=14, DIGIT_CYCLES=32)
REQ-032 Send 1234 decimal, brightness 15 -> digit register visible at T+15; scanning shows 4,3,2,1 glyphs 99,0D,25,9F on enable 1110,1101,1011,0111, 32 cycles each.
REQ-033 Send 42 with blank_lz=1 -> digits 3,2 enable stay 1111 in their slots; digits 1,0 show 99,25; blank_lz=0 -> digits 3,2 show 03.
REQ-034 Send 10000 decimal -> all four digits show FD; send 16'h... 14-bit 0x2BCD hex -> D,C,B,2 glyphs 85,63,C1,25, visible at T+2.
REQ-035 brightness=3 -> selected enable low for exactly 8 of 32 cycles per slot; brightness=0 -> 2 cycles.
REQ-036 Assert data_valid continuously with new values during CONVERT -> only handshakes with data_ready=1 accepted; display never shows partial value.
REQ-037 Assert reset at T+5 of a decimal conversion -> enable 1111, led_out FF next cycle; after release digit 0 shows 03.
